serial_sub: RTL and testbench

Parametrised multi-cycle subtractor computing diff = a − b − bin over WIDTH bits. It processes BITS_PER_CYCLE bits per clock through a chain of full-subtractor cells and carries the borrow between cycles in a register. It trades latency for area in the arithmetic datapath and replaces wide ripple subtractors where throughput is not critical. A start/busy/done handshake controls it.

---
 rtl/serial_sub.sv | 122 ++++++++++++
 tb/tb_serial_sub.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/serial_sub.sv
// Multi-cycle subtractor: diff = a - b - bin, BITS_PER_CYCLE bits per clock with a registered borrow.
// Optional macro SERIAL_SUB_SAT_EN: saturate diff to 0 when the final borrow is set.
module serial_sub #(
  parameter int unsigned WIDTH          = 8,
  parameter int unsigned BITS_PER_CYCLE = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bor
);

  localparam int unsigned N     = WIDTH / BITS_PER_CYCLE;
  localparam int unsigned CNT_W = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_e;

  state_e                    state_q, state_d;
  logic [WIDTH-1:0]          a_sh_q, a_sh_d;
  logic [WIDTH-1:0]          b_sh_q, b_sh_d;
  logic                      br_q, br_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic [WIDTH-1:0]          work_q, work_d;
  logic [WIDTH-1:0]          diff_q, diff_d;
  logic                      bor_q, bor_d;
  logic                      busy_q, busy_d;
  logic                      done_q, done_d;
  logic [BITS_PER_CYCLE-1:0] slice_diff;
  logic                      br_chain;

  // Chain of full-subtractor cells over the low slice of the operand registers
  always_comb begin
    br_chain   = br_q;
    slice_diff = '0;
    for (int i = 0; i < int'(BITS_PER_CYCLE); i++) begin
      slice_diff[i] = a_sh_q[i] ^ b_sh_q[i] ^ br_chain;
      br_chain      = (~a_sh_q[i] & br_chain) | (b_sh_q[i] & br_chain) | (~a_sh_q[i] & b_sh_q[i]);
    end
  end

  // Next-state and datapath updates
  always_comb begin
    state_d = state_q;
    a_sh_d  = a_sh_q;
    b_sh_d  = b_sh_q;
    br_d    = br_q;
    cnt_d   = cnt_q;
    work_d  = work_q;
    diff_d  = diff_q;
    bor_d   = bor_q;
    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          a_sh_d  = a;
          b_sh_d  = b;
          br_d    = bin;
          cnt_d   = '0;
          state_d = S_RUN;
        end else if (state_q == S_DONE) begin
          state_d = S_IDLE;
        end
      end
      S_RUN: begin
        a_sh_d = a_sh_q >> BITS_PER_CYCLE;
        b_sh_d = b_sh_q >> BITS_PER_CYCLE;
        br_d   = br_chain;
        work_d = WIDTH'({slice_diff, work_q} >> BITS_PER_CYCLE);
        cnt_d  = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(N - 1)) begin
`ifdef SERIAL_SUB_SAT_EN
          diff_d = br_chain ? '0 : work_d;
`else
          diff_d = work_d;
`endif
          bor_d   = br_chain;
          state_d = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d == S_RUN);
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      br_q    <= 1'b0;
      cnt_q   <= '0;
      work_q  <= '0;
      diff_q  <= '0;
      bor_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      br_q    <= br_d;
      cnt_q   <= cnt_d;
      work_q  <= work_d;
      diff_q  <= diff_d;
      bor_q   <= bor_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign diff = diff_q;
  assign bor  = bor_q;

endmodule

// File: tb/tb_serial_sub.sv
// Self-checking bench for serial_sub: WIDTH=8 with BITS_PER_CYCLE=1 and 4 instances, random ops vs an arithmetic model.
module tb_serial_sub;

  localparam int unsigned W  = 8;
  localparam int unsigned N1 = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0, bin = 1'b0;
  logic [W-1:0] a = '0, b = '0;
  logic         busy, done, bor;
  logic [W-1:0] diff;
  logic         start4 = 1'b0, bin4 = 1'b0;
  logic [W-1:0] a4 = '0, b4 = '0;
  logic         busy4, done4, bor4;
  logic [W-1:0] diff4;

  int unsigned  n_cmp = 0;
  int unsigned  n_err = 0;
  logic [W-1:0] prev_diff = '0;
  logic         prev_bor = 1'b0;

  serial_sub #(.WIDTH(W), .BITS_PER_CYCLE(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .bin(bin),
    .busy(busy), .done(done), .diff(diff), .bor(bor)
  );

  serial_sub #(.WIDTH(W), .BITS_PER_CYCLE(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .a(a4), .b(b4), .bin(bin4),
    .busy(busy4), .done(done4), .diff(diff4), .bor(bor4)
  );

  always #5 clk = ~clk;

  // Reference: unsigned arithmetic, optional saturation
  function automatic logic [W:0] model(input logic [W-1:0] ma, input logic [W-1:0] mb, input logic mbin);
    int unsigned ia, ib, ic;
    logic [W-1:0] d;
    logic         br;
    ia = ma; ib = mb; ic = mbin;
    br = (ia < ib + ic);
    d  = W'((ia - ib - ic) & 32'hFF);
`ifdef SERIAL_SUB_SAT_EN
    if (br) d = '0;
`endif
    return {br, d};
  endfunction

  // Issues an op at the current negedge and checks the whole run; returns at the DONE-cycle negedge.
  task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input logic tbin, input string name);
    logic [W:0] exp;
    exp   = model(ta, tb_v, tbin);
    start = 1'b1; a = ta; b = tb_v; bin = tbin;
    @(negedge clk);
    start = 1'b0; a = W'($urandom); b = W'($urandom); bin = 1'($urandom);
    for (int c = 1; c <= int'(N1); c++) begin
      n_cmp++;
      if (busy !== 1'b1 || done !== 1'b0) begin
        n_err++;
        $display("FAIL %s run c%0d: busy=%b done=%b required busy=1 done=0", name, c, busy, done);
      end
      n_cmp++;
      if (diff !== prev_diff || bor !== prev_bor) begin
        n_err++;
        $display("FAIL %s hold c%0d: diff=%h bor=%b required diff=%h bor=%b", name, c, diff, bor, prev_diff, prev_bor);
      end
      @(negedge clk);
    end
    n_cmp++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL %s done: busy=%b done=%b required busy=0 done=1", name, busy, done);
    end
    n_cmp++;
    if (diff !== exp[W-1:0] || bor !== exp[W]) begin
      n_err++;
      $display("FAIL %s result: diff=%h bor=%b required diff=%h bor=%b", name, diff, bor, exp[W-1:0], exp[W]);
    end
    prev_diff = exp[W-1:0];
    prev_bor  = exp[W];
  endtask

  task automatic test_reset;
    n_cmp++;
    if (busy !== 1'b0 || done !== 1'b0 || diff !== '0 || bor !== 1'b0) begin
      n_err++;
      $display("FAIL reset: busy=%b done=%b diff=%h bor=%b required all 0", busy, done, diff, bor);
    end
    n_cmp++;
    if (busy4 !== 1'b0 || done4 !== 1'b0 || diff4 !== '0 || bor4 !== 1'b0) begin
      n_err++;
      $display("FAIL reset4: busy=%b done=%b diff=%h bor=%b required all 0", busy4, done4, diff4, bor4);
    end
  endtask

  task automatic test_directed;
    run_op(8'h5A, 8'h3C, 1'b0, "dir_5a_3c");
    @(negedge clk);
    n_cmp++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL idle_after_done: busy=%b done=%b required 0 0", busy, done);
    end
    run_op(8'h00, 8'h01, 1'b0, "dir_00_01");
    @(negedge clk);
    run_op(8'hFF, 8'hFF, 1'b1, "dir_ff_ff_bin");
    @(negedge clk);
    run_op(8'hFF, 8'h00, 1'b1, "dir_ff_00_bin");
    @(negedge clk);
  endtask

  task automatic test_random;
    for (int k = 0; k < 20; k++) begin
      run_op(W'($urandom), W'($urandom), 1'($urandom), "random");
      repeat (1 + $urandom_range(0, 2)) @(negedge clk);
    end
  endtask

  task automatic test_bpc4;
    logic [W:0] exp;
    logic [W-1:0] ta [2];
    logic [W-1:0] tbv [2];
    ta[0] = 8'h10; tbv[0] = 8'h0F; ta[1] = 8'h10; tbv[1] = 8'h10;
    for (int k = 0; k < 2; k++) begin
      exp    = model(ta[k], tbv[k], 1'b1);
      start4 = 1'b1; a4 = ta[k]; b4 = tbv[k]; bin4 = 1'b1;
      @(negedge clk);
      start4 = 1'b0; a4 = W'($urandom); b4 = W'($urandom);
      for (int c = 1; c <= 2; c++) begin
        n_cmp++;
        if (busy4 !== 1'b1 || done4 !== 1'b0) begin
          n_err++;
          $display("FAIL bpc4 run%0d c%0d: busy=%b done=%b required 1 0", k, c, busy4, done4);
        end
        @(negedge clk);
      end
      n_cmp++;
      if (done4 !== 1'b1 || busy4 !== 1'b0 || diff4 !== exp[W-1:0] || bor4 !== exp[W]) begin
        n_err++;
        $display("FAIL bpc4 result%0d: done=%b busy=%b diff=%h bor=%b required 1 0 %h %b",
                 k, done4, busy4, diff4, bor4, exp[W-1:0], exp[W]);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_start_in_run;
    logic [W:0] exp;
    int         ndone;
    exp   = model(8'hC3, 8'h21, 1'b0);
    ndone = 0;
    start = 1'b1; a = 8'hC3; b = 8'h21; bin = 1'b0;
    @(negedge clk);
    start = 1'b0;
    for (int c = 1; c <= 12; c++) begin
      if (c == 3) begin
        start = 1'b1; a = 8'h01; b = 8'h77; bin = 1'b1;
      end else begin
        start = 1'b0;
      end
      if (done === 1'b1) ndone++;
      if (c <= int'(N1)) begin
        n_cmp++;
        if (busy !== 1'b1) begin
          n_err++;
          $display("FAIL start_in_run busy c%0d: busy=%b required 1", c, busy);
        end
      end
      if (c == int'(N1) + 1) begin
        n_cmp++;
        if (done !== 1'b1 || diff !== exp[W-1:0] || bor !== exp[W]) begin
          n_err++;
          $display("FAIL start_in_run result: done=%b diff=%h bor=%b required 1 %h %b", done, diff, bor, exp[W-1:0], exp[W]);
        end
      end
      @(negedge clk);
    end
    n_cmp++;
    if (ndone !== 1) begin
      n_err++;
      $display("FAIL start_in_run done_count: got %0d required 1", ndone);
    end
    prev_diff = exp[W-1:0];
    prev_bor  = exp[W];
  endtask

  task automatic test_back_to_back;
    run_op(8'h40, 8'h41, 1'b0, "b2b_first");
    run_op(8'hFF, 8'h01, 1'b0, "b2b_second");
    @(negedge clk);
  endtask

  task automatic test_reset_mid;
    run_op(8'h9C, 8'h13, 1'b0, "pre_reset");
    @(negedge clk);
    start = 1'b1; a = 8'hA5; b = 8'h05; bin = 1'b0;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (busy !== 1'b0 || done !== 1'b0 || diff !== '0 || bor !== 1'b0) begin
      n_err++;
      $display("FAIL reset_mid: busy=%b done=%b diff=%h bor=%b required all 0", busy, done, diff, bor);
    end
    @(negedge clk);
    rst_n = 1'b1;
    prev_diff = '0;
    prev_bor  = 1'b0;
    for (int c = 0; c < 10; c++) begin
      n_cmp++;
      if (done !== 1'b0 || busy !== 1'b0) begin
        n_err++;
        $display("FAIL reset_mid no_done c%0d: busy=%b done=%b required 0 0", c, busy, done);
      end
      @(negedge clk);
    end
    run_op(8'h33, 8'h34, 1'b1, "post_reset");
    @(negedge clk);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    test_reset;
    rst_n = 1'b1;
    @(negedge clk);
    test_directed;
    test_random;
    test_bpc4;
    test_start_in_run;
    test_back_to_back;
    test_reset_mid;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
